// File: rtl/detect_event_logger_if.sv
// Event read-side handshake bundle for detect_event_logger.
// The logger drives it through the master modport and the host reads through the slave modport.
interface detect_event_logger_if #(
    parameter int TS_WIDTH  = 16,
    parameter int IDX_WIDTH = 8
);
    logic                 ev_valid;
    logic                 ev_ready;
    logic [TS_WIDTH-1:0]  ev_timestamp;
    logic [IDX_WIDTH-1:0] ev_index;

    modport master (
        output ev_valid,
        output ev_timestamp,
        output ev_index,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_timestamp,
        input  ev_index,
        output ev_ready
    );
endinterface

// File: rtl/detect_event_logger.sv
// Timestamps detection pulses and queues them in a first-word-fall-through FIFO, with a sticky overflow flag.
// Optional macro DETECT_LOGGER_GAP_FILTER_EN rejects detections closer than MIN_GAP edges apart.
module detect_event_logger #(
    parameter int TS_WIDTH  = 16,
    parameter int IDX_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int MIN_GAP   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  detected,
    input  logic                  clear_overflow,
    output logic [IDX_WIDTH-1:0]  total_count,
    output logic                  overflow,
    detect_event_logger_if.master ev
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MIN_GAP < 1) begin : g_bad_cfg
        $error("detect_event_logger: DEPTH must be a power of 2 >= 2 and MIN_GAP >= 1");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [TS_WIDTH-1:0]  r_ts;
    logic [IDX_WIDTH-1:0] r_total;
    logic                 r_overflow;
    logic [TS_WIDTH-1:0]  r_head_ts;
    logic [IDX_WIDTH-1:0] r_head_idx;
    logic [TS_WIDTH-1:0]  r_ts_mem  [DEPTH];
    logic [IDX_WIDTH-1:0] r_idx_mem [DEPTH];

    logic                 w_accept;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [PTR_W-1:0]     w_head_next;
    logic [CNT_W-1:0]     w_count_next;
    logic [TS_WIDTH-1:0]  w_head_ts_next;
    logic [IDX_WIDTH-1:0] w_head_idx_next;

`ifdef DETECT_LOGGER_GAP_FILTER_EN
    localparam int GAP_W = $clog2(MIN_GAP + 1);

    logic [GAP_W-1:0] r_since;
    logic             r_seen;

    // r_since saturates at MIN_GAP: it is the edge distance to the last accepted detection.
    assign w_accept = detected && (!r_seen || r_since >= GAP_W'(MIN_GAP));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_seen  <= 1'b0;
            r_since <= '0;
        end else if (w_accept) begin
            r_seen  <= 1'b1;
            r_since <= GAP_W'(1);
        end else if (r_since < GAP_W'(MIN_GAP)) begin
            r_since <= r_since + GAP_W'(1);
        end
    end
`else
    assign w_accept = detected;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_pop        = (r_state != ST_EMPTY) && ev.ev_ready;
        w_push       = w_accept && ((r_state != ST_FULL) || w_pop);
        w_drop       = w_accept && !w_push;
        w_head_next  = w_pop ? r_head + PTR_W'(1) : r_head;
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_state_next = r_state;

        case (r_state)
            ST_EMPTY: begin
                if (w_push) w_state_next = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (w_push && !w_pop && r_count == CNT_W'(DEPTH - 1))
                    w_state_next = ST_FULL;
                else if (w_pop && !w_push && r_count == CNT_W'(1))
                    w_state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_pop && !w_push) w_state_next = ST_PARTIAL;
            end
            default: w_state_next = ST_EMPTY;
        endcase

        // The entry being written this edge becomes head when it lands in the head slot.
        if (w_push && w_head_next == r_tail) begin
            w_head_ts_next  = r_ts;
            w_head_idx_next = r_total;
        end else begin
            w_head_ts_next  = r_ts_mem[w_head_next];
            w_head_idx_next = r_idx_mem[w_head_next];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_total    <= '0;
            r_overflow <= 1'b0;
            r_head_ts  <= '0;
            r_head_idx <= '0;
        end else begin
            r_ts    <= r_ts + TS_WIDTH'(1);
            r_head  <= w_head_next;
            r_count <= w_count_next;
            r_state <= w_state_next;
            if (w_accept) r_total <= r_total + IDX_WIDTH'(1);
            if (w_push)   r_tail  <= r_tail + PTR_W'(1);
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clear_overflow)
                r_overflow <= 1'b0;
            // Head registers only move while an entry exists, so they hold the last value when empty.
            if (w_state_next != ST_EMPTY) begin
                r_head_ts  <= w_head_ts_next;
                r_head_idx <= w_head_idx_next;
            end
        end
    end

    // NOTE: storage has no reset; validity is tracked by the pointers and occupancy alone.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_ts_mem[r_tail]  <= r_ts;
            r_idx_mem[r_tail] <= r_total;
        end
    end

    assign ev.ev_valid     = (r_state != ST_EMPTY);
    assign ev.ev_timestamp = r_head_ts;
    assign ev.ev_index     = r_head_idx;
    assign total_count     = r_total;
    assign overflow        = r_overflow;
endmodule

// File: tb/tb_detect_event_logger.sv
// Directed, table-driven bench for detect_event_logger (DEPTH=4, MIN_GAP=3).
// Inputs change and outputs are sampled on the falling edge.
module tb_detect_event_logger;
    logic       clk = 1'b0;
    logic       reset;
    logic       detected;
    logic       clear_overflow;
    logic [7:0] total_count;
    logic       overflow;
    int         n_checks = 0;
    int         n_errors = 0;

    detect_event_logger_if #(.TS_WIDTH(16), .IDX_WIDTH(8)) ev_if ();

    detect_event_logger #(
        .TS_WIDTH(16), .IDX_WIDTH(8), .DEPTH(4), .MIN_GAP(3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .detected       (detected),
        .clear_overflow (clear_overflow),
        .total_count    (total_count),
        .overflow       (overflow),
        .ev             (ev_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic det;
        logic rdy;
        logic clr;
        logic exp_valid;
        int   exp_ts;
        int   exp_idx;
        int   exp_total;
        logic exp_ovf;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic v, input int ts, input int idx,
                             input int tot, input logic ovf);
        check({tag, ".valid"}, int'(ev_if.ev_valid), int'(v));
        check({tag, ".ts"},    int'(ev_if.ev_timestamp), ts);
        check({tag, ".idx"},   int'(ev_if.ev_index), idx);
        check({tag, ".total"}, int'(total_count), tot);
        check({tag, ".ovf"},   int'(overflow), int'(ovf));
    endtask

    task automatic do_reset();
        detected       = 1'b0;
        clear_overflow = 1'b0;
        ev_if.ev_ready = 1'b0;
        reset          = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[26];
        int   gap_n;
        int   gap_ts[4];
        int   gap_total;

        @(negedge clk);
        do_reset();
        check_all("reset", 1'b0, 0, 0, 0, 1'b0);

`ifndef DETECT_LOGGER_GAP_FILTER_EN
        // Vector k is applied on the edge where the timestamp counter reads k.
        //              det rdy clr  valid ts idx tot ovf
        for (int k = 0; k < 5; k++) vecs[k] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 1,  5, 0,  1, 0};
        vecs[6]  = '{0, 1, 0, 0,  5, 0,  1, 0};
        vecs[7]  = '{0, 0, 0, 0,  5, 0,  1, 0};
        vecs[8]  = '{0, 0, 0, 0,  5, 0,  1, 0};
        vecs[9]  = '{0, 0, 0, 0,  5, 0,  1, 0};
        vecs[10] = '{1, 0, 0, 1, 10, 1,  2, 0};
        vecs[11] = '{1, 0, 0, 1, 10, 1,  3, 0};
        vecs[12] = '{1, 0, 0, 1, 10, 1,  4, 0};
        vecs[13] = '{1, 0, 0, 1, 10, 1,  5, 0};
        vecs[14] = '{1, 0, 0, 1, 10, 1,  6, 1};
        vecs[15] = '{1, 0, 0, 1, 10, 1,  7, 1};
        vecs[16] = '{0, 0, 1, 1, 10, 1,  7, 0};
        vecs[17] = '{1, 0, 1, 1, 10, 1,  8, 1};
        vecs[18] = '{1, 1, 0, 1, 11, 2,  9, 1};
        vecs[19] = '{0, 1, 0, 1, 12, 3,  9, 1};
        vecs[20] = '{0, 1, 0, 1, 13, 4,  9, 1};
        vecs[21] = '{0, 1, 0, 1, 18, 8,  9, 1};
        vecs[22] = '{0, 1, 0, 0, 18, 8,  9, 1};
        vecs[23] = '{1, 1, 0, 1, 23, 9, 10, 1};
        vecs[24] = '{1, 1, 0, 1, 24, 10, 11, 1};
        vecs[25] = '{0, 0, 0, 1, 24, 10, 11, 1};

        for (int k = 0; k < 26; k++) begin
            detected       = vecs[k].det;
            ev_if.ev_ready = vecs[k].rdy;
            clear_overflow = vecs[k].clr;
            tick();
            check_all($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_ts,
                      vecs[k].exp_idx, vecs[k].exp_total, vecs[k].exp_ovf);
        end

        // Queue two more behind the head, then reset with detected high on the reset edge.
        detected = 1'b1; ev_if.ev_ready = 1'b0; clear_overflow = 1'b0;
        tick();
        tick();
        check("mid.total_before", int'(total_count), 13);
        reset = 1'b0;
        tick();
        check_all("mid_reset", 1'b0, 0, 0, 0, 1'b0);
        reset = 1'b1; detected = 1'b0;
        repeat (3) tick();
        detected = 1'b1;
        tick();
        check_all("post_reset_first", 1'b1, 3, 0, 1, 1'b0);

        // Fill from a fresh index base, overflow twice, then drain in order.
        repeat (5) tick();
        detected = 1'b0;
        check_all("refill_full", 1'b1, 3, 0, 6, 1'b1);
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d.valid", i), int'(ev_if.ev_valid), 1);
            check($sformatf("drain%0d.ts", i), int'(ev_if.ev_timestamp), 3 + i);
            check($sformatf("drain%0d.idx", i), int'(ev_if.ev_index), i);
            tick();
        end
        check("drain_end.valid", int'(ev_if.ev_valid), 0);
        check("drain_end.ts_hold", int'(ev_if.ev_timestamp), 6);
        ev_if.ev_ready = 1'b0;
`endif

        // Detections on four consecutive edges at ts 20..23.
        do_reset();
`ifdef DETECT_LOGGER_GAP_FILTER_EN
        gap_n = 2; gap_total = 2;
        gap_ts[0] = 20; gap_ts[1] = 23; gap_ts[2] = 0; gap_ts[3] = 0;
`else
        gap_n = 4; gap_total = 4;
        gap_ts[0] = 20; gap_ts[1] = 21; gap_ts[2] = 22; gap_ts[3] = 23;
`endif
        repeat (20) tick();
        detected = 1'b1;
        repeat (4) tick();
        detected = 1'b0;
        check("gap.total", int'(total_count), gap_total);
        check("gap.ovf", int'(overflow), 0);
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < gap_n; i++) begin
            check($sformatf("gap%0d.valid", i), int'(ev_if.ev_valid), 1);
            check($sformatf("gap%0d.ts", i), int'(ev_if.ev_timestamp), gap_ts[i]);
            check($sformatf("gap%0d.idx", i), int'(ev_if.ev_index), i);
            tick();
        end
        check("gap_end.valid", int'(ev_if.ev_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
